data_mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store interface: accepts one request at a time, performs the read/write on a word-organised RAM, returns a response after a fixed latency.

---
 rtl/data_mem_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder_pkg: response payload carried from the accept cycle to the response port.
// data_mem_responder: memory-side responder for the core's load/store port.
//   Takes one request at a time on a valid/ready handshake and performs the access on a
//   word-organised RAM. It returns the response LATENCY cycles after the accept and holds
//   it until rsp_ready.
//   Ports: clk, rstn (async, active low)
//          req_valid/req_ready handshake; req_we, req_addr, req_wdata, req_size, req_unsigned
//          rsp_valid/rsp_ready handshake; rsp_rdata (extended load data), rsp_err
package data_mem_responder_pkg;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NB    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  rsp_t             rsp_q, rsp_d;
  rsp_t             hold_q, hold_d;

  logic             accept_c;
  logic             enter_resp_c;
  logic             leave_resp_c;

  logic [31:0]      mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_c;
  logic [1:0]       lane_c;
  logic             oor_c;
  logic             misalign_c;
  logic             size_bad_c;
  logic             err_c;
  logic [NB-1:0]    be_c;
  logic [31:0]      wrep_c;
  logic [31:0]      rd_word_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      ld_c;
  rsp_t             res_c;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  // req_ready_q is high exactly in IDLE, so this is the handshake.
  assign accept_c = req_valid & req_ready_q;

  // Request address decode.
  assign idx_c  = req_addr[DEPTH_LOG2+1:2];
  assign lane_c = req_addr[1:0];
  assign oor_c  = |(req_addr >> (DEPTH_LOG2 + 2));

  // Size-dependent byte enables, lane replication and alignment check.
  always_comb begin
    be_c       = '0;
    wrep_c     = req_wdata;
    misalign_c = 1'b0;
    size_bad_c = 1'b0;
    case (req_size)
      2'b00: begin
        be_c   = NB'(4'b0001 << lane_c);
        wrep_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c       = req_addr[1] ? 4'b1100 : 4'b0011;
        wrep_c     = {2{req_wdata[15:0]}};
        misalign_c = req_addr[0];
      end
      2'b10: begin
        be_c       = 4'b1111;
        misalign_c = |lane_c;
      end
      default: size_bad_c = 1'b1;
    endcase
  end

  assign err_c = oor_c | misalign_c | size_bad_c;

  // Load path: addressed word, lane select, then sign/zero extension.
  assign rd_word_c = mem_q[idx_c];

  always_comb begin
    byte_c = rd_word_c[7:0];
    case (lane_c)
      2'd0:    byte_c = rd_word_c[7:0];
      2'd1:    byte_c = rd_word_c[15:8];
      2'd2:    byte_c = rd_word_c[23:16];
      default: byte_c = rd_word_c[31:24];
    endcase
    half_c = req_addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    case (req_size)
      2'b00:   ld_c = req_unsigned ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   ld_c = req_unsigned ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
      default: ld_c = rd_word_c;
    endcase
    res_c.err   = err_c;
    res_c.rdata = (err_c || req_we) ? 32'd0 : ld_c;
  end

  // Store commits on the accept edge, so the next transaction always sees it.
  always_ff @(posedge clk) begin
    if (accept_c && req_we && !err_c) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be_c[b]) begin
          mem_q[idx_c][8*b +: 8] <= wrep_c[8*b +: 8];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: latency counter, handshake flags and response payload.
  // The counter starts at 1 on accept so that RESP is entered LATENCY edges after it.
  always_comb begin
    cnt_d        = '0;
    enter_resp_c = 1'b0;
    leave_resp_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (LATENCY == 1) begin
            enter_resp_c = 1'b1;
          end else begin
            cnt_d = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: leave_resp_c = rsp_ready;
      default: cnt_d = '0;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);

    hold_d = accept_c ? res_c : hold_q;

    rsp_d = rsp_q;
    if (enter_resp_c) begin
      rsp_d = accept_c ? res_c : hold_q;
    end else if (leave_resp_c) begin
      rsp_d = '0;
    end
  end

  // Counter, handshake and payload registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      hold_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed checks of data_mem_responder.
//   Two instances (LATENCY 2 and 1) share stimulus and are exercised one at a time.
//   The byte-level memory model lives in this bench.
module tb_data_mem_responder;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_ready;
  int          sel;

  logic        rv_in0, rv_in1, rr_in0, rr_in1;
  logic        rq_rdy0, rq_rdy1, rs_vld0, rs_vld1, rs_err0, rs_err1;
  logic [31:0] rs_dat0, rs_dat1;
  logic        rr_m, rv_m, err_m;
  logic [31:0] rd_m;

  int n_checks;
  int n_errors;

  logic [31:0] mem_m [0:1][0:4095];

  assign rv_in0 = req_valid && (sel == 0);
  assign rv_in1 = req_valid && (sel == 1);
  assign rr_in0 = rsp_ready && (sel == 0);
  assign rr_in1 = rsp_ready && (sel == 1);
  assign rr_m   = (sel == 0) ? rq_rdy0 : rq_rdy1;
  assign rv_m   = (sel == 0) ? rs_vld0 : rs_vld1;
  assign err_m  = (sel == 0) ? rs_err0 : rs_err1;
  assign rd_m   = (sel == 0) ? rs_dat0 : rs_dat1;

  data_mem_responder #(.DEPTH_LOG2(12), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rstn(rstn),
    .req_valid(rv_in0), .req_ready(rq_rdy0), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rs_vld0), .rsp_ready(rr_in0), .rsp_rdata(rs_dat0), .rsp_err(rs_err0)
  );

  data_mem_responder #(.DEPTH_LOG2(12), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rstn(rstn),
    .req_valid(rv_in1), .req_ready(rq_rdy1), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rs_vld1), .rsp_ready(rr_in1), .rsp_rdata(rs_dat1), .rsp_err(rs_err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t required before 400000", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (lat=%0d): got 0x%08h expected 0x%08h", tag, (sel == 0) ? 2 : 1, got, exp);
    end
  endtask

  // Byte-addressed reference: error rules, byte-wise store, byte-wise load plus extension.
  task automatic model_access(input int s, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                              output logic [31:0] rd, output logic e);
    int nb;
    int w;
    int l;
    logic [31:0] val;
    nb = 1 << sz;
    e  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
         (a >= 32'h0000_4000);
    rd = 32'd0;
    if (e) return;
    val = 32'd0;
    for (int i = 0; i < nb; i++) begin
      w = int'((a + 32'(i)) >> 2);
      l = int'((a + 32'(i)) % 32'd4);
      if (we) mem_m[s][w][l*8 +: 8] = wd[i*8 +: 8];
      else    val[i*8 +: 8] = mem_m[s][w][l*8 +: 8];
    end
    if (!we) begin
      if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
      rd = val;
    end
  endtask

  // One full transaction with latency, stall-stability and release checks.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int hold,
                        output logic [31:0] rd, output logic err);
    int n;
    int lat;
    logic [31:0] exp_rd;
    logic exp_err;
    lat = (sel == 0) ? 2 : 1;
    n = 0;
    while (!rr_m && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_ready", 32'(rr_m), 32'd1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    chk("ready_after_accept", 32'(rr_m), 32'd0);
    n = 1;
    while (!rv_m && n < 20) begin
      rsp_ready = 1'($urandom);
      req_valid = 1'($urandom);
      chk("rdata_while_wait", rd_m, 32'd0);
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(lat));
    rd  = rd_m;
    err = err_m;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", 32'(rv_m), 32'd1);
      chk("stall_ready", 32'(rr_m), 32'd0);
      chk("stall_rdata", rd_m, rd);
      chk("stall_err", 32'(err_m), 32'(err));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("release_valid", 32'(rv_m), 32'd0);
    chk("release_ready", 32'(rr_m), 32'd1);
    chk("release_rdata", rd_m, 32'd0);
    chk("release_err", 32'(err_m), 32'd0);
    model_access(sel, we, addr, wdata, size, uns, exp_rd, exp_err);
    chk("rdata", rd, exp_rd);
    chk("err", 32'(err), 32'(exp_err));
  endtask

  task automatic dir(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input int hold, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic err;
    do_txn(we, addr, wdata, size, uns, hold, rd, err);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic reset_mid_txn();
    logic [31:0] rd;
    logic err;
    req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'hA5A5_A5A5;
    req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_access(sel, 1'b1, 32'h200, 32'hA5A5_A5A5, 2'b10, 1'b0, rd, err);
    rstn = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rv_m), 32'd0);
    chk("rst_async_ready", 32'(rr_m), 32'd1);
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_valid", 32'(rv_m), 32'd0);
      chk("rst_ready", 32'(rr_m), 32'd1);
    end
    dir("rst_lw", 1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 1, 32'hA5A5_A5A5, 1'b0);
  endtask

  task automatic run_suite();
    logic [31:0] rd;
    logic [31:0] a;
    logic err;
    int r;
    for (int w = 0; w < 64; w++) begin
      do_txn(1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, 0, rd, err);
    end
    dir("sw",   1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 32'h0, 1'b0);
    dir("lw",   1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 5, 32'hDEAD_BEEF, 1'b0);
    dir("lb",   1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 0, 32'hFFFF_FFDE, 1'b0);
    dir("lbu",  1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 1, 32'h0000_00DE, 1'b0);
    dir("lh",   1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 0, 32'hFFFF_DEAD, 1'b0);
    dir("lhu",  1'b0, 32'h100, 32'h0, 2'b01, 1'b1, 2, 32'h0000_BEEF, 1'b0);
    dir("sb",   1'b1, 32'h101, 32'hFFFF_FF12, 2'b00, 1'b0, 0, 32'h0, 1'b0);
    dir("lw_sb", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 32'hDEAD_12EF, 1'b0);
    dir("sh",   1'b1, 32'h102, 32'hABCD_5678, 2'b01, 1'b0, 0, 32'h0, 1'b0);
    dir("lw_sh", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 32'h5678_12EF, 1'b0);
    dir("lw_mis", 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b1);
    dir("lh_mis", 1'b0, 32'h101, 32'h0, 2'b01, 1'b0, 0, 32'h0, 1'b1);
    dir("size3", 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 0, 32'h0, 1'b1);
    dir("sw_oor", 1'b1, 32'h4000, 32'h1111_1111, 2'b10, 1'b0, 0, 32'h0, 1'b1);
    dir("sw_mis", 1'b1, 32'h101, 32'h2222_2222, 2'b10, 1'b0, 0, 32'h0, 1'b1);
    dir("lw_keep", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 32'h5678_12EF, 1'b0);
    dir("lw_top", 1'b0, 32'h3FFC, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b0 === 1'b1);
    reset_mid_txn();
    for (int t = 0; t < 150; t++) begin
      r = int'($urandom % 10);
      if (r == 0) a = 32'h0000_4000 | $urandom;
      else        a = $urandom % 256;
      do_txn(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom),
             int'($urandom % 4), rd, err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    sel = 0;
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b0;
    mem_m[0][32'hFFC] = 32'h0;
    mem_m[1][32'hFFC] = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk("reset_ready", 32'(rr_m), 32'd1);
      chk("reset_valid", 32'(rv_m), 32'd0);
      chk("reset_rdata", rd_m, 32'd0);
      chk("reset_err", 32'(err_m), 32'd0);
    end
    sel = 0;
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      logic [31:0] rd;
      logic err;
      sel = s;
      do_txn(1'b1, 32'h3FFC, 32'h0, 2'b10, 1'b0, 0, rd, err);
      run_suite();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
